countdown_timer: RTL and testbench

- Programmable seconds countdown that consumes the one-pulse-per-second enable produced by the clock divider stage.
- Loads a duration on a start pulse and decrements once per enable pulse.
- Emits a one-cycle expired strobe to the controlling FSM (alarm/sequencer logic).
- Runs entirely in the system clock domain; the enable is a qualifier, never a clock.

---
 rtl/countdown_timer_if.sv | 36 +++
 rtl/countdown_timer.sv | 93 +++++++++
 tb/tb_countdown_timer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and status bundle between the countdown timer and its controlling FSM.
// The pause wire exists only when COUNTDOWN_TIMER_PAUSE_EN is defined.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             oneHertz_enable;
  logic             start;
  logic [WIDTH-1:0] value;
  logic             cancel;
`ifdef COUNTDOWN_TIMER_PAUSE_EN
  logic             pause;
`endif
  logic             expired;
  logic             busy;
  logic [WIDTH-1:0] remaining;

`ifdef COUNTDOWN_TIMER_PAUSE_EN
  modport master (
    output oneHertz_enable, start, value, cancel, pause,
    input  expired, busy, remaining
  );
  modport slave (
    input  oneHertz_enable, start, value, cancel, pause,
    output expired, busy, remaining
  );
`else
  modport master (
    output oneHertz_enable, start, value, cancel,
    input  expired, busy, remaining
  );
  modport slave (
    input  oneHertz_enable, start, value, cancel,
    output expired, busy, remaining
  );
`endif
endinterface

// File: rtl/countdown_timer.sv
// Seconds countdown: loads on start and decrements on each enable tick. All outputs are
// registered (one edge from input to output), there is no backpressure, and COUNTDOWN_TIMER_PAUSE_EN adds a pause input.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input logic               clock,
  input logic               reset,
  countdown_timer_if.slave  tmr
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] remaining_q;
  logic [WIDTH-1:0] remaining_d;
  logic             busy_q;
  logic             busy_d;
  logic             expired_q;
  logic             expired_d;

  logic             hold;
  logic             tick;
  logic             last_tick;
  logic             load_zero;

`ifdef COUNTDOWN_TIMER_PAUSE_EN
  assign hold = tmr.pause;
`else
  assign hold = 1'b0;
`endif

  // A forced count of 0 in RUN is treated like 1 so the decrement can never wrap.
  assign tick      = tmr.oneHertz_enable & ~hold;
  assign last_tick = (remaining_q <= WIDTH'(1));
  assign load_zero = (tmr.value == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      expired_q   <= expired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmr.start) begin
      state_d = load_zero ? IDLE : RUN;
    end else if (state_q == RUN) begin
      if (tmr.cancel) begin
        state_d = IDLE;
      end else if (tick && last_tick) begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    expired_d   = 1'b0;
    busy_d      = (state_d == RUN);
    if (tmr.start) begin
      remaining_d = tmr.value;
      expired_d   = load_zero;
    end else if (state_q == RUN) begin
      if (tmr.cancel) begin
        remaining_d = '0;
      end else if (tick) begin
        if (last_tick) begin
          remaining_d = '0;
          expired_d   = 1'b1;
        end else begin
          remaining_d = remaining_q - WIDTH'(1);
        end
      end
    end
  end

  assign tmr.remaining = remaining_q;
  assign tmr.busy      = busy_q;
  assign tmr.expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic against a behavioural model.
module tb_countdown_timer;
  localparam int WIDTH = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  countdown_timer_if #(.WIDTH(WIDTH)) tif ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .tmr   (tif)
  );

  bit pause_drv = 1'b0;
`ifdef COUNTDOWN_TIMER_PAUSE_EN
  assign tif.pause = pause_drv;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: seconds left on the timer, whether it is counting, and the strobe.
  int m_rem = 0;
  bit m_run = 1'b0;
  bit m_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input int val, input bit cn,
                            input bit en, input bit ps);
    m_exp = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_rem = 0;
    end else if (st) begin
      m_rem = val;
      m_run = (val > 0);
      m_exp = (val == 0);
    end else if (m_run && cn) begin
      m_run = 1'b0;
      m_rem = 0;
    end else if (m_run && en && !ps) begin
      m_rem = m_rem - 1;
      if (m_rem <= 0) begin
        m_rem = 0;
        m_run = 1'b0;
        m_exp = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit rst, input bit st, input int val, input bit cn,
                       input bit en, input bit ps);
    reset               = rst;
    tif.start           = st;
    tif.value           = WIDTH'(val);
    tif.cancel          = cn;
    tif.oneHertz_enable = en;
    pause_drv           = ps;
    @(posedge clock);
    model_step(rst, st, val, cn, en, ps);
    #1;
    chk("remaining", tif.remaining, m_rem);
    chk("busy", tif.busy, m_run);
    chk("expired", tif.expired, m_exp);
  endtask

  // Idle cycles with an enable every 'period' cycles.
  task automatic run_ticks(input int cycles, input int period);
    for (int i = 0; i < cycles; i++) begin
      drive(1'b0, 1'b0, 0, 1'b0, (i % period) == (period - 1), 1'b0);
    end
  endtask

  initial begin
    int cnt;
    bit ps;

    drive(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("reset_remaining", tif.remaining, 0);
    chk("reset_busy", tif.busy, 0);

    // Load 5, enable every 4 cycles
    drive(1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    chk("load5_busy", tif.busy, 1);
    run_ticks(24, 4);

    // Zero-duration start expires immediately
    drive(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("zero_expired", tif.expired, 1);
    run_ticks(3, 2);

    // Retrigger from 3 to 7 with a coincident enable
    drive(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    run_ticks(4, 2);
    drive(1'b0, 1'b1, 7, 1'b0, 1'b1, 1'b0);
    chk("retrigger_remaining", tif.remaining, 7);
    run_ticks(20, 2);

    // Cancel mid-count, later enables do nothing
    drive(1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    run_ticks(6, 1);

    // Fast mode: enable every cycle from 15
    drive(1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    while (cnt < 40) begin
      drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      cnt++;
      if (tif.expired === 1'b1) break;
    end
    chk("fast_expiry_cycles", cnt, 15);
    run_ticks(4, 1);

    // Reset while counting at 2
    drive(1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0);
    run_ticks(2, 1);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("midrun_reset_busy", tif.busy, 0);
    run_ticks(3, 1);

`ifdef COUNTDOWN_TIMER_PAUSE_EN
    drive(1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk("paused_remaining", tif.remaining, 3);
    chk("paused_busy", tif.busy, 1);
    run_ticks(3, 1);
    chk("resume_expired", tif.expired, 1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
`ifdef COUNTDOWN_TIMER_PAUSE_EN
      ps = ($urandom_range(3) == 0);
`else
      ps = 1'b0;
`endif
      drive(($urandom_range(127) == 0),
            ($urandom_range(11) == 0),
            int'($urandom_range((1 << WIDTH) - 1)),
            ($urandom_range(23) == 0),
            ($urandom_range(1) == 0),
            ps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
